// File: rtl/k005297_pgcmp_pkg.sv
// rtl/k005297_pgcmp_pkg.sv - shared types, constants and parameter checks for the page comparator
package k005297_pgcmp_pkg;

    // Frames seen since the last page load; the comparison is trusted once FULL.
    typedef enum logic [1:0] {
        VCNT_IDLE = 2'd0,
        VCNT_ONE  = 2'd1,
        VCNT_FULL = 2'd2
    } vcnt_e;

    // Two's-complement addend that turns a serial add into "relative - WRAP_PAGE".
    function automatic int sub_const(input int pg_w, input int wrap_page);
        return (1 << pg_w) - wrap_page;
    endfunction

    // The frame must hold every page bit plus at least one idle slot.
    function automatic bit frame_len_ok(input int pg_w, input int frame_len);
        return frame_len >= pg_w + 1;
    endfunction

    // The timeout threshold must be reachable by the saturating miss counter.
    function automatic bit timeout_ok(input int miss_w, input int timeout_frames);
        return timeout_frames <= (1 << miss_w) - 1;
    endfunction

endpackage

// File: rtl/k005297_serial_addc.sv
// rtl/k005297_serial_addc.sv - bit-serial full adder with enabled carry and slot-0 carry clear
module k005297_serial_addc (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);

    logic carry_q;
    logic carry_d;
    logic cin;

    // Full-adder slice; the carry-in is forced to 0 on the first bit of a word.
    always_comb begin
        cin     = clr ? 1'b0 : carry_q;
        sum     = a ^ b ^ cin;
        cout    = (a & b) | (cin & (a ^ b));
        carry_d = en ? cout : carry_q;
    end

    // Carry register advances only on enabled slot cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/k005297_pgcmp_param.sv
// rtl/k005297_pgcmp_param.sv - serial relative-to-absolute page conversion and comparison
module k005297_pgcmp_param
    import k005297_pgcmp_pkg::*;
#(
    parameter int PG_W           = 12,
    parameter int FRAME_LEN      = 20,
    parameter int WRAP_PAGE      = 1299,
    parameter int ABS_OFFSET     = 754,
    parameter int MISS_W         = 4,
    parameter int TIMEOUT_FRAMES = 12
) (
    input  logic              i_MCLK,
    input  logic              i_RST,
    input  logic              i_CLK2M_PCEN_n,
    input  logic              i_FRAME_SYNC,
    input  logic              i_PG_LOAD,
    input  logic              i_BDI_EN,
    input  logic              i_PGREG_SR_LSB,
    input  logic              i_ABSPGCNTR_LSB,
    input  logic              i_UMODE_n,
    output logic              o_PGCMP_EQ,
    output logic              o_PGCMP_GTE,
    output logic              o_VALID,
    output logic              o_TIMEOUT,
    output logic              o_FRAME_ERR,
    output logic [MISS_W-1:0] o_MISS_CNT
);

    localparam int SLOT_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(FRAME_LEN - 1);
    localparam logic [SLOT_W-1:0] LATCH_SLOT = SLOT_W'(PG_W - 1);
    localparam logic [PG_W-1:0]   SUB_K      = PG_W'(sub_const(PG_W, WRAP_PAGE));
    localparam logic [PG_W-1:0]   ADD_K      = PG_W'(ABS_OFFSET);
    localparam logic [MISS_W-1:0] MISS_MAX   = '1;
    localparam logic [MISS_W-1:0] MISS_LIM   = MISS_W'(TIMEOUT_FRAMES);

    if (!frame_len_ok(PG_W, FRAME_LEN)) begin : g_bad_frame_len
        $error("FRAME_LEN must be at least PG_W+1");
    end
    if (!timeout_ok(MISS_W, TIMEOUT_FRAMES)) begin : g_bad_timeout
        $error("TIMEOUT_FRAMES exceeds the miss counter range");
    end

    // Slot timing
    logic              en;
    logic [SLOT_W-1:0] cur_slot;
    logic              slot0;
    logic              at_latch;
    logic [PG_W-1:0]   sub_k_vec;
    logic [PG_W-1:0]   add_k_vec;

    // Serial datapath
    logic sub_sum;
    logic sub_cout;
    logic add_sum;
    logic add_cout_unused;
    logic target_bit;
    logic cntr_bit;
    logic diff_now;
    logic gt_now;

    // State
    logic [SLOT_W-1:0] slot_q,    slot_d;
    logic              gte_flag_q, gte_flag_d;
    logic              diff_q,    diff_d;
    logic              gt_q,      gt_d;
    logic              eq_q,      eq_d;
    logic              gte_out_q, gte_out_d;
    vcnt_e             vcnt_q,    vcnt_d;
    logic              valid_q,   valid_d;
    logic [MISS_W-1:0] miss_q,    miss_d;
    logic              timeout_q, timeout_d;
    logic              ferr_q,    ferr_d;

    // Slot decode: a frame sync forces the current cycle to slot 0.
    always_comb begin
        en        = ~i_CLK2M_PCEN_n;
        cur_slot  = i_FRAME_SYNC ? '0 : slot_q;
        slot0     = (cur_slot == '0);
        at_latch  = (cur_slot == LATCH_SLOT);
        sub_k_vec = SUB_K >> cur_slot;
        add_k_vec = ADD_K >> cur_slot;
    end

    // Relative page minus WRAP_PAGE; its final carry says the page is at or past the wrap.
    k005297_serial_addc u_sub (
        .clk  (i_MCLK),
        .rst  (i_RST),
        .en   (en),
        .clr  (slot0),
        .a    (i_PGREG_SR_LSB),
        .b    (sub_k_vec[0]),
        .sum  (sub_sum),
        .cout (sub_cout)
    );

    // Relative page plus ABS_OFFSET; this path wraps modulo 2^PG_W so its carry is dropped.
    k005297_serial_addc u_add (
        .clk  (i_MCLK),
        .rst  (i_RST),
        .en   (en),
        .clr  (slot0),
        .a    (i_PGREG_SR_LSB),
        .b    (add_k_vec[0]),
        .sum  (add_sum),
        .cout (add_cout_unused)
    );

    // Target selection and LSB-first equality / magnitude accumulation.
    always_comb begin
        cntr_bit   = i_ABSPGCNTR_LSB;
        target_bit = i_BDI_EN ? (gte_flag_q ? sub_sum : add_sum) : i_PGREG_SR_LSB;
        diff_now   = (slot0 ? 1'b0 : diff_q) | (target_bit ^ cntr_bit);
        gt_now     = (cntr_bit & ~target_bit)
                   | (~(cntr_bit ^ target_bit) & (slot0 ? 1'b0 : gt_q));
    end

    // Next-state: slot counter, accumulators, result latch, valid pipeline, misses, framing.
    always_comb begin
        slot_d     = slot_q;
        gte_flag_d = gte_flag_q;
        diff_d     = diff_q;
        gt_d       = gt_q;
        eq_d       = eq_q;
        gte_out_d  = gte_out_q;
        vcnt_d     = vcnt_q;
        miss_d     = miss_q;
        ferr_d     = ferr_q;

        if (en) begin
            slot_d = (cur_slot == LAST_SLOT) ? '0 : cur_slot + SLOT_W'(1);
            diff_d = diff_now;
            gt_d   = gt_now;

            if (i_FRAME_SYNC && (slot_q != '0)) begin
                ferr_d = 1'b1;
            end

            if (at_latch) begin
                // The flag captured here steers the conversion of the next frame.
                gte_flag_d = sub_cout;
                eq_d       = ~diff_now & ~i_UMODE_n & valid_q;
                gte_out_d  = (~diff_now | gt_now) & valid_q;

                case (vcnt_q)
                    VCNT_IDLE: vcnt_d = VCNT_ONE;
                    default:   vcnt_d = VCNT_FULL;
                endcase

                if (valid_q && !i_UMODE_n) begin
                    if (!diff_now) begin
                        miss_d = '0;
                    end else if (miss_q != MISS_MAX) begin
                        miss_d = miss_q + MISS_W'(1);
                    end
                end
            end

            // A page reload overrides anything latched in the same cycle.
            if (i_PG_LOAD) begin
                vcnt_d = VCNT_IDLE;
                miss_d = '0;
                ferr_d = 1'b0;
            end
        end

        valid_d   = (vcnt_d == VCNT_FULL);
        timeout_d = (miss_d >= MISS_LIM);
    end

    // State registers with asynchronous clear.
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            slot_q     <= '0;
            gte_flag_q <= 1'b0;
            diff_q     <= 1'b0;
            gt_q       <= 1'b0;
            eq_q       <= 1'b0;
            gte_out_q  <= 1'b0;
            vcnt_q     <= VCNT_IDLE;
            valid_q    <= 1'b0;
            miss_q     <= '0;
            timeout_q  <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            gte_flag_q <= gte_flag_d;
            diff_q     <= diff_d;
            gt_q       <= gt_d;
            eq_q       <= eq_d;
            gte_out_q  <= gte_out_d;
            vcnt_q     <= vcnt_d;
            valid_q    <= valid_d;
            miss_q     <= miss_d;
            timeout_q  <= timeout_d;
            ferr_q     <= ferr_d;
        end
    end

    assign o_PGCMP_EQ  = eq_q;
    assign o_PGCMP_GTE = gte_out_q;
    assign o_VALID     = valid_q;
    assign o_TIMEOUT   = timeout_q;
    assign o_FRAME_ERR = ferr_q;
    assign o_MISS_CNT  = miss_q;

endmodule

// File: tb/tb_k005297_pgcmp_param.sv
// tb/tb_k005297_pgcmp_param.sv - self-checking bench for the page comparator
module tb_k005297_pgcmp_param;

    localparam int PG_W      = 12;
    localparam int FRAME_LEN = 20;
    localparam int WRAP      = 1299;
    localparam int OFF       = 754;
    localparam int MISS_W    = 4;
    localparam int TMO       = 12;
    localparam int PG_MOD    = 1 << PG_W;
    localparam int MISS_SAT  = (1 << MISS_W) - 1;

    logic clk = 1'b0;
    logic rst, pcen_n, fsync, load, bdi, pg_bit, cnt_bit, umode_n;
    logic eq, gte, valid, timeout, ferr;
    logic [MISS_W-1:0] miss;

    int n_tests = 0;
    int n_fail  = 0;
    bit gaps_on = 1'b0;

    int m_cnt, m_miss;
    bit m_gte_prev, m_eq, m_gte, m_err;

    always #5 clk = ~clk;

    k005297_pgcmp_param #(
        .PG_W(PG_W), .FRAME_LEN(FRAME_LEN), .WRAP_PAGE(WRAP),
        .ABS_OFFSET(OFF), .MISS_W(MISS_W), .TIMEOUT_FRAMES(TMO)
    ) dut (
        .i_MCLK          (clk),
        .i_RST           (rst),
        .i_CLK2M_PCEN_n  (pcen_n),
        .i_FRAME_SYNC    (fsync),
        .i_PG_LOAD       (load),
        .i_BDI_EN        (bdi),
        .i_PGREG_SR_LSB  (pg_bit),
        .i_ABSPGCNTR_LSB (cnt_bit),
        .i_UMODE_n       (umode_n),
        .o_PGCMP_EQ      (eq),
        .o_PGCMP_GTE     (gte),
        .o_VALID         (valid),
        .o_TIMEOUT       (timeout),
        .o_FRAME_ERR     (ferr),
        .o_MISS_CNT      (miss)
    );

    // ---------------- reference model (frame level) ----------------
    function automatic int model_target(input int rel, input bit b);
        if (!b) return rel;
        if (m_gte_prev) return (rel + PG_MOD - WRAP) % PG_MOD;
        return (rel + OFF) % PG_MOD;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_miss = 0; m_gte_prev = 0; m_eq = 0; m_gte = 0; m_err = 0;
    endtask

    task automatic model_frame(input int rel, input int ctr, input bit b, input bit u, input bit ld);
        int tgt;
        bit match, vld;
        if (ld) begin m_cnt = 0; m_miss = 0; m_err = 0; end
        tgt   = model_target(rel, b);
        match = (ctr == tgt);
        vld   = (m_cnt == 2);
        m_eq  = match && !u && vld;
        m_gte = (ctr >= tgt) && vld;
        if (vld && !u) m_miss = match ? 0 : ((m_miss < MISS_SAT) ? m_miss + 1 : MISS_SAT);
        m_cnt = (m_cnt < 2) ? m_cnt + 1 : 2;
        m_gte_prev = (rel >= WRAP);
    endtask

    function automatic logic [8:0] exp_vec();
        return {m_eq, m_gte, (m_cnt == 2), (m_miss >= TMO), m_err, 4'(m_miss)};
    endfunction

    function automatic logic [8:0] obs_vec();
        return {eq, gte, valid, timeout, ferr, miss};
    endfunction

    // ---------------- stimulus ----------------
    task automatic drive_slot(input bit sync, input bit ld, input bit pb, input bit cb);
        int gap;
        gap = (gaps_on && ($urandom_range(0, 3) == 0)) ? $urandom_range(1, 2) : 0;
        repeat (gap) begin
            @(negedge clk);
            pcen_n = 1'b1;
            fsync = 1'($urandom); load = 1'($urandom);
            pg_bit = 1'($urandom); cnt_bit = 1'($urandom);
        end
        @(negedge clk);
        pcen_n = 1'b0; fsync = sync; load = ld; pg_bit = pb; cnt_bit = cb;
        @(posedge clk);
        #1;
        pcen_n = 1'b1; fsync = 1'b0; load = 1'b0;
    endtask

    task automatic run_frame(input int rel, input int ctr, input bit b, input bit u, input bit ld);
        logic [PG_W-1:0] r, c;
        r = PG_W'(rel);
        c = PG_W'(ctr);
        bdi = b;
        umode_n = u;
        for (int s = 0; s < FRAME_LEN; s++) begin
            drive_slot(s == 0, ld && (s == 0),
                       (s < PG_W) ? r[s] : 1'($urandom),
                       (s < PG_W) ? c[s] : 1'($urandom));
        end
        model_frame(rel, ctr, b, u, ld);
    endtask

    task automatic partial_frame(input int nslots);
        for (int s = 0; s < nslots; s++) drive_slot(s == 0, 1'b0, 1'($urandom), 1'($urandom));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; pcen_n = 1'b1; fsync = 0; load = 0; bdi = 0;
        pg_bit = 0; cnt_bit = 0; umode_n = 0;
        model_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if (obs_vec() !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", obs_vec(), 9'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_wrap_boundary();
        for (int f = 1; f <= 3; f++) begin
            run_frame(1299, 0, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL wrap_frame%0d: got %b expected %b", f, obs_vec(), exp_vec());
            end
        end
        n_tests++;
        if ({eq, gte, valid} !== 3'b111) begin
            n_fail++;
            $display("FAIL wrap_eq_gte_valid: got %b expected 111", {eq, gte, valid});
        end
    endtask

    task automatic test_add_path();
        int ctrs[4] = '{2052, 2052, 2051, 2053};
        foreach (ctrs[i]) begin
            run_frame(1298, ctrs[i], 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL add_path ctr=%0d step%0d: got %b expected %b", ctrs[i], i, obs_vec(), exp_vec());
            end
            if (i == 1) begin
                n_tests++;
                if (eq !== 1'b1) begin
                    n_fail++;
                    $display("FAIL add_path_eq_2052: got %b expected 1", eq);
                end
            end
        end
    endtask

    task automatic test_bdi_raw();
        run_frame(0, 754, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (eq !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL raw_mode: got %b expected %b", obs_vec(), exp_vec());
        end
        run_frame(0, 754, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (eq !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL bdi_convert: got %b expected %b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_umode();
        run_frame(0, 5, 1'b1, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) begin
            run_frame(0, (f == 2) ? 9 : 754, 1'b1, 1'b1, 1'b0);
            n_tests++;
            if (obs_vec() !== exp_vec() || miss !== 4'd1) begin
                n_fail++;
                $display("FAIL umode_frame%0d: got %b expected %b", f, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_timeout();
        run_frame(100, 0, 1'b1, 1'b0, 1'b1);
        run_frame(100, 0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            run_frame(100, 0, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (obs_vec() !== exp_vec() || int'(miss) != ((k < MISS_SAT) ? k : MISS_SAT)
                || timeout !== (k >= TMO)) begin
                n_fail++;
                $display("FAIL miss_step%0d: got %b expected %b", k, obs_vec(), exp_vec());
            end
        end
        run_frame(100, 0, 1'b1, 1'b0, 1'b1);
        n_tests++;
        if ({valid, timeout, miss} !== 6'd0 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL load_clears: got %b expected %b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_frame_err();
        partial_frame(7);
        m_err = 1'b1;
        for (int f = 0; f < 2; f++) begin
            run_frame(1299, 0, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (ferr !== 1'b1 || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL frame_err_sticky%0d: got %b expected %b", f, obs_vec(), exp_vec());
            end
        end
        partial_frame(7);
        m_err = 1'b1;
        run_frame(1299, 0, 1'b1, 1'b0, 1'b1);
        n_tests++;
        if (ferr !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL frame_err_load_wins: got %b expected %b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        for (int f = 0; f < 3; f++) run_frame(1299, 0, 1'b1, 1'b0, 1'b0);
        partial_frame(5);
        rst = 1'b1;
        #1;
        n_tests++;
        if (obs_vec() !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got %b expected %b", obs_vec(), 9'd0);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int f = 1; f <= 3; f++) begin
            run_frame(1299, 0, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL after_reset_frame%0d: got %b expected %b", f, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            int rel, ctr, tgt, pick;
            bit b, u, ld;
            rel  = $urandom_range(0, PG_MOD - 1);
            b    = ($urandom_range(0, 4) != 0);
            u    = ($urandom_range(0, 4) == 0);
            ld   = ($urandom_range(0, 9) == 0);
            tgt  = model_target(rel, b);
            pick = $urandom_range(0, 3);
            case (pick)
                0, 1:    ctr = tgt;
                2:       ctr = (tgt + PG_MOD + (($urandom_range(0, 1) == 0) ? -1 : 1)) % PG_MOD;
                default: ctr = $urandom_range(0, PG_MOD - 1);
            endcase
            run_frame(rel, ctr, b, u, ld);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_frame%0d rel=%0d ctr=%0d bdi=%0d um=%0d ld=%0d: got %b expected %b",
                         f, rel, ctr, b, u, ld, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        gaps_on = 1'b1;
        test_wrap_boundary();
        test_add_path();
        test_bdi_raw();
        test_umode();
        test_timeout();
        test_frame_err();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
